// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and
// instruction memory.
//
//   imem_req     fetch side -> memory : request valid this cycle
//   imem_addr    fetch side -> memory : fetch address (word aligned)
//   imem_gnt     memory -> fetch side : request accepted this cycle
//   imem_rvalid  memory -> fetch side : imem_rdata carries the response
//   imem_rdata   memory -> fetch side : returned instruction word
//
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues one request at a time to instruction
// memory, forwards the returned word into the IF/ID register, parks the word
// in a one-entry hold buffer while the pipeline is stalled, and flushes or
// drains in-flight traffic when EX redirects the PC.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   stall             hazard unit holds IF/ID this cycle
//   redirect          taken branch/jump from EX: flush and refetch
//   redirect_pc       redirect target (low two bits ignored)
//   imem              instruction-memory bus (master side)
//   ifid_we           IF/ID register write enable
//   ifid_empty        IF/ID bubble select (1 = write zero)
//   ifid_pc           PC of the delivered instruction (0 when empty)
//   ifid_instr        delivered instruction word (0 when empty)
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    imem,
  output logic            ifid_we,
  output logic            ifid_empty,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_instr
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  // REQ   : request on the bus, waiting for grant
  // WAIT  : granted, waiting for the response we intend to use
  // HOLD  : response captured while stalled, waiting for the stall to clear
  // DRAIN : granted request was flushed, waiting to swallow its response
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] hold_buf;
  logic [XLEN-1:0] hold_nxt;
  logic            req;
  logic            deliver;
  logic [XLEN-1:0] deliver_word;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_tgt;

  // Sequential increment wraps naturally at 2^XLEN.
  assign pc_inc       = pc + PC_STEP;
  assign redirect_tgt = redirect_pc & ALIGN_MASK;

  // State, PC and hold buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      hold_buf <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      hold_buf <= hold_nxt;
    end
  end

  // Next-state, PC update and delivery selection. Redirect is checked first
  // in every state so that it wins over stall and every other transition.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    hold_nxt     = hold_buf;
    req          = 1'b0;
    deliver      = 1'b0;
    deliver_word = '0;

    case (state)
      S_REQ: begin
        req = 1'b1;
        if (redirect) begin
          pc_nxt = redirect_tgt;
          // A grant in the redirect cycle was for the old PC; its response
          // must still be swallowed before the next request.
          state_nxt = imem.imem_gnt ? S_DRAIN : S_REQ;
        end else if (imem.imem_gnt) begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          pc_nxt    = redirect_tgt;
          state_nxt = imem.imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem.imem_rvalid) begin
          if (stall) begin
            hold_nxt  = imem.imem_rdata;
            state_nxt = S_HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_word = imem.imem_rdata;
            pc_nxt       = pc_inc;
            state_nxt    = S_REQ;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_nxt    = redirect_tgt;
          hold_nxt  = '0;
          state_nxt = S_REQ;
        end else if (!stall) begin
          deliver      = 1'b1;
          deliver_word = hold_buf;
          pc_nxt       = pc_inc;
          state_nxt    = S_REQ;
        end
      end

      S_DRAIN: begin
        if (redirect) begin
          pc_nxt    = redirect_tgt;
          state_nxt = S_DRAIN;
        end else if (imem.imem_rvalid) begin
          state_nxt = S_REQ;
        end
      end

      default: begin
        state_nxt = S_REQ;
      end
    endcase

    // Reset abandons any request this cycle.
    if (rst) begin
      req = 1'b0;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  // IF/ID control: reset and redirect flush, delivery writes the word,
  // otherwise a bubble when free and a hold when stalled.
  always_comb begin
    ifid_we    = 1'b1;
    ifid_empty = 1'b1;
    ifid_pc    = '0;
    ifid_instr = '0;
    if (rst || redirect) begin
      ifid_we    = 1'b1;
      ifid_empty = 1'b1;
    end else if (deliver) begin
      ifid_empty = 1'b0;
      ifid_pc    = pc;
      ifid_instr = deliver_word;
    end else begin
      ifid_we = !stall;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_we;
  logic        ifid_empty;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .ifid_we     (ifid_we),
    .ifid_empty  (ifid_empty),
    .ifid_pc     (ifid_pc),
    .ifid_instr  (ifid_instr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Transaction-level reference: expected PC, whether a granted request is
  // outstanding, whether its response is to be thrown away, and whether a
  // returned word is parked waiting for a stall to clear.
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_gnt_addr = RESET_PC;
  bit          m_pending = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_held = 1'b0;

  // Instruction memory contents: a fixed scramble of the address unless
  // overridden for a directed step.
  logic [31:0] mem_ovr [logic [31:0]];

  logic [31:0] last_req, last_addr, last_we, last_empty, last_pc, last_instr;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs 1 ns
  // later, advance the reference model, then wait for the rising edge.
  task automatic step(input int r, input int s, input int rd, input logic [31:0] rpc,
                      input int g, input int v);
    bit          br, bs, bg, rv, rdr, exp_req, exp_dlv, exp_we;
    logic [31:0] exp_word;
    @(negedge clk);
    br  = (r != 0);
    bs  = (s != 0);
    bg  = (g != 0);
    // Memory only answers a granted request, and is flushed by reset.
    rv  = (v != 0) && m_pending && !br;
    // A redirect coinciding with the response of a flushed request would
    // leave the unit waiting for a response that never comes; keep apart.
    rdr = (rd != 0) && !(m_pending && m_stale && rv);
    rst             = br;
    stall           = bs;
    redirect        = rdr;
    redirect_pc     = rpc;
    bus.imem_gnt    = bg;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_rd(m_gnt_addr) : $urandom;
    #1;
    exp_req  = !br && !m_pending && !m_held;
    exp_dlv  = !br && !rdr && !bs && ((m_pending && !m_stale && rv) || m_held);
    exp_we   = (br || rdr || exp_dlv) ? 1'b1 : !bs;
    exp_word = mem_rd(m_pc);

    last_req   = {31'b0, bus.imem_req};
    last_addr  = bus.imem_addr;
    last_we    = {31'b0, ifid_we};
    last_empty = {31'b0, ifid_empty};
    last_pc    = ifid_pc;
    last_instr = ifid_instr;

    chk("imem_req", last_req, {31'b0, exp_req});
    if (!br) chk("imem_addr", last_addr, m_pc);
    chk("ifid_we", last_we, {31'b0, exp_we});
    chk("ifid_empty", last_empty, {31'b0, !exp_dlv});
    chk("ifid_pc", last_pc, exp_dlv ? m_pc : 32'h0);
    chk("ifid_instr", last_instr, exp_dlv ? exp_word : 32'h0);

    if (br) begin
      m_pc = RESET_PC; m_pending = 1'b0; m_stale = 1'b0; m_held = 1'b0;
    end else if (rdr) begin
      if (exp_req && bg) begin
        m_gnt_addr = m_pc; m_pending = 1'b1; m_stale = 1'b1;
      end else if (m_pending && rv) begin
        m_pending = 1'b0; m_stale = 1'b0;
      end else if (m_pending) begin
        m_stale = 1'b1;
      end
      m_held = 1'b0;
      m_pc   = {rpc[31:2], 2'b00};
    end else if (exp_req) begin
      if (bg) begin
        m_gnt_addr = m_pc; m_pending = 1'b1; m_stale = 1'b0;
      end
    end else if (m_pending && rv) begin
      m_pending = 1'b0;
      if (m_stale) m_stale = 1'b0;
      else if (bs) m_held = 1'b1;
      else m_pc = m_pc + 32'd4;
    end else if (m_held && !bs) begin
      m_held = 1'b0;
      m_pc   = m_pc + 32'd4;
    end
    @(posedge clk);
  endtask

  task automatic peek_addr(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, bus.imem_addr, exp);
  endtask

  initial begin
    rst             = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    mem_ovr[32'h0000_000C] = 32'h00A0_0093;

    // Reset state
    step(1, 0, 0, 32'h0, 0, 0);
    step(1, 0, 0, 32'h0, 1, 1);
    chk("rst_req", last_req, 32'd0);
    chk("rst_we", last_we, 32'd1);
    chk("rst_empty", last_empty, 32'd1);
    peek_addr("rst_addr", RESET_PC);

    // Straight-line fetch with 1-cycle grant and 1-cycle latency
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0, 1, 0);
      chk("seq_bubble_we", last_we, 32'd1);
      chk("seq_bubble_empty", last_empty, 32'd1);
      step(0, 0, 0, 32'h0, 0, 1);
      chk("seq_dlv_pc", last_pc, 32'(i * 4));
      chk("seq_dlv_empty", last_empty, 32'd0);
    end

    // Stall on response: hold, then deliver the held word
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 1, 0, 32'h0, 0, 1);
    chk("hold_we", last_we, 32'd0);
    step(0, 1, 0, 32'h0, 0, 0);
    chk("hold_we2", last_we, 32'd0);
    step(0, 0, 0, 32'h0, 0, 0);
    chk("hold_instr", last_instr, 32'h00A0_0093);
    chk("hold_pc", last_pc, 32'h0000_000C);
    peek_addr("hold_next_addr", 32'h0000_0010);

    // Redirect while waiting: drain stale response, refetch aligned target
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 1, 32'h0000_0103, 0, 0);
    chk("redir_we", last_we, 32'd1);
    chk("redir_empty", last_empty, 32'd1);
    step(0, 0, 0, 32'h0, 1, 1);
    chk("drain_empty", last_empty, 32'd1);
    chk("drain_req", last_req, 32'd0);
    peek_addr("redir_addr", 32'h0000_0100);

    // Redirect and stall together in HOLD
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 1, 0, 32'h0, 0, 1);
    step(0, 1, 1, 32'h0000_0200, 0, 0);
    chk("hold_redir_we", last_we, 32'd1);
    chk("hold_redir_empty", last_empty, 32'd1);
    peek_addr("hold_redir_addr", 32'h0000_0200);
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 0, 1);
    chk("hold_redir_dlv_pc", last_pc, 32'h0000_0200);
    chk("hold_redir_dlv_instr", last_instr, mem_rd(32'h0000_0200));

    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 0, 1);
    chk("wrap_dlv_pc", last_pc, 32'hFFFF_FFFC);
    peek_addr("wrap_addr", 32'h0000_0000);

    // Reset mid-WAIT, grant withheld for three cycles
    step(0, 0, 0, 32'h0, 1, 0);
    step(1, 0, 0, 32'h0, 0, 1);
    chk("midrst_req", last_req, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0, 0, 0);
      chk("midrst_req_hi", last_req, 32'd1);
      chk("midrst_addr", last_addr, RESET_PC);
      chk("midrst_empty", last_empty, 32'd1);
    end
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 0, 1);
    chk("midrst_dlv_pc", last_pc, RESET_PC);
    chk("midrst_dlv_empty", last_empty, 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      int          r, s, rd, g, v;
      logic [31:0] rpc;
      r   = ($urandom_range(199, 0) == 0) ? 1 : 0;
      s   = ($urandom_range(9, 0) < 3) ? 1 : 0;
      rd  = ($urandom_range(19, 0) == 0) ? 1 : 0;
      g   = ($urandom_range(9, 0) < 6) ? 1 : 0;
      v   = ($urandom_range(1, 0) == 0) ? 1 : 0;
      rpc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF9 : $urandom;
      step(r, s, rd, rpc, g, v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
